// File: rtl/wb_pkg.sv
// Shared writeback definitions: payload widths and the per-requester result record.
package wb_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned PREG_W = 6;
    localparam int unsigned ROB_W  = 5;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [PREG_W-1:0] dest;
        logic              wb;
        logic [ROB_W-1:0]  rob_id;
    } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first valid index at or above ptr, wrapping modulo N.
module rr_arbiter #(
    parameter int unsigned N  = 3,
    parameter int unsigned PW = 2
) (
    input  logic [N-1:0]  valid,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] idx,
    output logic          any
);

    int unsigned cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = 0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = 32'(ptr) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (!any && valid[PW'(cand)]) begin
                any                = 1'b1;
                grant[PW'(cand)]   = 1'b1;
                idx                = PW'(cand);
            end
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares one register-file write port and one ROB completion port among NREQ
// variable-latency units with round-robin grant, registered outputs and flush squash.
module wb_port_arbiter
    import wb_pkg::*;
#(
    parameter int unsigned NREQ = 3,
    parameter int unsigned CNTW = 16
) (
    input  logic                   cpu_clock_i,
    input  logic                   cpu_resetn_i,
    input  logic                   flush_i,
    input  logic [NREQ-1:0]        req_valid_i,
    input  logic [NREQ*DATA_W-1:0] req_data_i,
    input  logic [NREQ*PREG_W-1:0] req_dest_i,
    input  logic [NREQ-1:0]        req_wb_i,
    input  logic [NREQ*ROB_W-1:0]  req_rob_id_i,
    output logic [NREQ-1:0]        req_ready_o,
    output logic [DATA_W-1:0]      wb_data_o,
    output logic [PREG_W-1:0]      wb_dest_o,
    output logic                   wb_wen_o,
    output logic [ROB_W-1:0]       rob_id_o,
    output logic                   rob_valid_o,
    output logic [CNTW-1:0]        contention_o
);

    localparam int unsigned PW = $clog2(NREQ);

    wb_req_t            reqs [NREQ];
    wb_req_t            sel;
    logic [NREQ-1:0]    raw_grant;
    logic [PW-1:0]      gidx;
    logic               gany;
    logic               take;
    logic               contend;
    logic [PW-1:0]      next_ptr;

    logic [PW-1:0]      ptr_q;
    logic [DATA_W-1:0]  data_q;
    logic [PREG_W-1:0]  dest_q;
    logic [ROB_W-1:0]   rob_q;
    logic               wen_q;
    logic               rv_q;
    logic [CNTW-1:0]    cnt_q;

    // Unpack the flat requester buses into per-unit records.
    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign reqs[i] = {req_data_i[DATA_W*i +: DATA_W],
                          req_dest_i[PREG_W*i +: PREG_W],
                          req_wb_i[i],
                          req_rob_id_i[ROB_W*i +: ROB_W]};
    end

    rr_arbiter #(
        .N  (NREQ),
        .PW (PW)
    ) u_rr (
        .valid (req_valid_i),
        .ptr   (ptr_q),
        .grant (raw_grant),
        .idx   (gidx),
        .any   (gany)
    );

    assign req_ready_o = flush_i ? '0 : raw_grant;
    assign take        = gany & ~flush_i;
    assign sel         = reqs[gidx];
    assign contend     = ($countones(req_valid_i) >= 2) && !flush_i;
    assign next_ptr    = (gidx == PW'(NREQ - 1)) ? '0 : gidx + 1'b1;

    always_ff @(posedge cpu_clock_i or negedge cpu_resetn_i) begin
        if (!cpu_resetn_i) begin
            ptr_q  <= '0;
            data_q <= '0;
            dest_q <= '0;
            rob_q  <= '0;
            wen_q  <= 1'b0;
            rv_q   <= 1'b0;
            cnt_q  <= '0;
        end else begin
            wen_q <= take & sel.wb;
            rv_q  <= take;
            if (take) begin
                data_q <= sel.data;
                dest_q <= sel.dest;
                rob_q  <= sel.rob_id;
                ptr_q  <= next_ptr;
            end
            if (contend && (cnt_q != '1)) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    // A flush also kills the result already on the ports this cycle.
    assign wb_wen_o     = wen_q & ~flush_i;
    assign rob_valid_o  = rv_q & ~flush_i;
    assign wb_data_o    = data_q;
    assign wb_dest_o    = dest_q;
    assign rob_id_o     = rob_q;
    assign contention_o = cnt_q;

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares one register-file write port and one ROB completion port among NREQ variable-latency execution units (e.g. multiply, divide, load).
- Sits between those units and the physical register file / ROB, beside the single-cycle ALU writeback stage, which keeps its own port.
- Round-robin valid/ready arbitration with a registered output stage, squash on flush, and a saturating contention counter for performance monitoring.

Parameters:
- NREQ, 3, number of requesting units (2..8).
- CNTW, 16, width of the contention counter.

Ports:
- cpu_clock_i  in  1  core clock.
- cpu_resetn_i  in  1  reset; asynchronous, active-low.
- flush_i  in  1  pipeline flush; squashes all writeback activity this cycle.
- req_valid_i  in  NREQ  requester i holds a result.
- req_data_i  in  NREQ*32  result data, packed, requester i at [32i+:32].
- req_dest_i  in  NREQ*6  physical destination register.
- req_wb_i  in  NREQ  result writes the register file (0 = ROB completion only).
- req_rob_id_i  in  NREQ*5  ROB entry id.
- req_ready_o  out  NREQ  one-hot grant; the transfer occurs when valid&ready.
- wb_data_o  out  32  register-file write data.
- wb_dest_o  out  6  register-file write destination.
- wb_wen_o  out  1  register-file write enable.
- rob_id_o  out  5  completing ROB id.
- rob_valid_o  out  1  ROB completion strobe.
- contention_o  out  CNTW  count of cycles in which more than one requester was valid.

Behaviour:
- Reset values (asynchronous on cpu_resetn_i low): wb_data_o=0, wb_dest_o=0, wb_wen_o=0, rob_id_o=0, rob_valid_o=0, contention_o=0, rr pointer=0.
- Grant is combinational:
  - Pick the first valid requester scanning from ptr upward, modulo NREQ.
  - req_ready_o is one-hot at that index, or all zero if none are valid or flush_i=1.
- Requester rules:
  - Once asserted, req_valid_i and its payload are held stable until ready.
  - A requester may drop valid only on a flush.
- Latency: a grant in cycle N drives wb_*/rob_* in cycle N+1, for exactly one cycle.
  - rob_valid_o=1.
  - wb_wen_o = req_wb_i of the granted requester.
  - data, dest and rob_id are taken from the granted requester.
- No grant in cycle N: rob_valid_o=0 and wb_wen_o=0 in N+1. Data, dest and id are don't-care but hold their previous value.
- Pointer: on a grant to index g, ptr <= (g+1) mod NREQ. Without a grant, ptr holds.
  - Guarantees each continuously valid requester a grant within NREQ cycles.
- Flush:
  - flush_i in cycle N forces req_ready_o=0 in N.
  - flush_i in cycle N also clears rob_valid_o and wb_wen_o registered for N+1.
  - An output already presented in cycle N (granted in N-1) is gated combinationally: wb_wen_o and rob_valid_o are ANDed with !flush_i.
  - The pointer is unchanged by a flush.
- Single requester valid: granted every cycle, giving full throughput of one writeback per cycle.
- Contention counter: increments when popcount(req_valid_i) >= 2 and flush_i=0; saturates at all-ones and never wraps.
- Reset mid-operation clears all state immediately; pending requests are lost, and requesters are reset by the same signal.

Decomposition:
- Shared package (wb_pkg):
  - localparam widths DATA_W=32, PREG_W=6, ROB_W=5.
  - packed struct wb_req_t {data, dest, wb, rob_id}, reused by all writeback stages.
- Natural sub-module: rr_arbiter (NREQ-wide, valid vector plus pointer in, one-hot grant plus index out). It is purely combinational; the pointer register stays in the parent.

Test Plan:
- Reset: cpu_resetn_i low for 3 cycles mid-traffic. All outputs read 0 asynchronously and ptr=0; the first grant after release goes to requester 0 when all three are valid.
- Single requester: req 1 valid with data=0xDEADBEEF, dest=12, wb=1, rob=7. ready[1]=1 that cycle; the next cycle shows wb_wen_o=1, wb_data_o=0xDEADBEEF, wb_dest_o=12, rob_id_o=7, rob_valid_o=1.
- All three valid continuously for 6 cycles: grants 0,1,2,0,1,2; contention_o increments by 6.
- ROB-only completion: wb=0, rob=3. rob_valid_o=1, rob_id_o=3, wb_wen_o=0.
- Flush: grant in cycle N, flush_i in N+1. wb_wen_o and rob_valid_o are 0 in N+1; no ready asserted in N+1; ptr is unchanged, so the next grant resumes the rotation.
- Saturation: with CNTW=4, hold 2 requesters valid for 20 cycles. contention_o stops at 15.
